// File: rtl/hwag_pulse_pkg.sv
// Shared types for the HWAG period pulse generator.
//   pg_state_t : FSM state encoding (IDLE / RUN)
//   PG_MODE_*  : encodings of the mode input sampled on start
package hwag_pulse_pkg;

  typedef enum logic {
    PG_IDLE = 1'b0,
    PG_RUN  = 1'b1
  } pg_state_t;

  localparam logic PG_MODE_CONT    = 1'b0;
  localparam logic PG_MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/period_shadow.sv
// Single-entry shadow buffer for the next period word.
//   clk, arst  : clock, async active-high reset
//   per_data   : incoming period word
//   per_valid  : per_data valid
//   per_ready  : buffer empty (registered: inverse of the full flag)
//   consume    : the FSM takes the buffered word this edge
//   shadow     : buffered word
//   full       : buffer holds an unconsumed word
module period_shadow #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] per_data,
  input  logic             per_valid,
  output logic             per_ready,
  input  logic             consume,
  output logic [WIDTH-1:0] shadow,
  output logic             full
);

  // consume only happens when full, and a load only when empty, so the
  // two never overlap; consume is still given precedence explicitly.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shadow <= '0;
      full   <= 1'b0;
    end else if (consume) begin
      full   <= 1'b0;
    end else if (per_valid && !full) begin
      shadow <= per_data;
      full   <= 1'b1;
    end
  end

  assign per_ready = ~full;

endmodule

// File: rtl/period_pulse_gen.sv
// Programmable down-counting tick generator: converts a period word into
// a strobe stream, one pulse every P enabled clocks (P=0 means 2**WIDTH).
//   clk, arst  : clock, async active-high reset
//   ena        : count enable; counter and FSM advance only when high
//   per_data/per_valid/per_ready : period handshake into the shadow buffer
//   mode       : 0 continuous, 1 one-shot (sampled on start)
//   start/stop : start request / abort request
//   pulse      : one-clock strobe at terminal count
//   busy       : FSM in RUN
//   count      : current down-count value
//   start_err  : one-clock flag, start seen in IDLE with no period buffered
module period_pulse_gen
  import hwag_pulse_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             ena,
  input  logic [WIDTH-1:0] per_data,
  input  logic             per_valid,
  output logic             per_ready,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  output logic             pulse,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             start_err
);

  pg_state_t        state, state_nxt;
  logic [WIDTH-1:0] period, period_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             mode_r, mode_nxt;
  logic             pulse_nxt, err_nxt;
  logic             consume;
  logic [WIDTH-1:0] shadow;
  logic             full;

  period_shadow #(.WIDTH(WIDTH)) u_shadow (
    .clk       (clk),
    .arst      (arst),
    .per_data  (per_data),
    .per_valid (per_valid),
    .per_ready (per_ready),
    .consume   (consume),
    .shadow    (shadow),
    .full      (full)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= PG_IDLE;
      count     <= '0;
      period    <= '0;
      mode_r    <= PG_MODE_CONT;
      pulse     <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      period    <= period_nxt;
      mode_r    <= mode_nxt;
      pulse     <= pulse_nxt;
      start_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    period_nxt = period;
    mode_nxt   = mode_r;
    pulse_nxt  = 1'b0;
    err_nxt    = 1'b0;
    consume    = 1'b0;
    case (state)
      PG_IDLE: begin
        // stop is meaningless here; start is only acted on while enabled
        if (ena && start) begin
          if (full) begin
            state_nxt  = PG_RUN;
            count_nxt  = shadow;
            period_nxt = shadow;
            mode_nxt   = mode;
            consume    = 1'b1;
          end else begin
            err_nxt    = 1'b1;
          end
        end
      end
      PG_RUN: begin
        // stop is an abort and acts even while the count is frozen
        if (stop) begin
          state_nxt = PG_IDLE;
          count_nxt = '0;
        end else if (ena) begin
          if (count == WIDTH'(1)) begin
            pulse_nxt = 1'b1;
            if (mode_r == PG_MODE_ONESHOT) begin
              state_nxt = PG_IDLE;
              count_nxt = '0;
            end else if (full) begin
              count_nxt  = shadow;
              period_nxt = shadow;
              consume    = 1'b1;
            end else begin
              count_nxt  = period;
            end
          end else begin
            // wraps 0 -> all-ones, giving 2**WIDTH cycles for period 0
            count_nxt = count - WIDTH'(1);
          end
        end
      end
      default: state_nxt = PG_IDLE;
    endcase
  end

  assign busy = (state == PG_RUN);

endmodule

// File: tb/tb_period_pulse_gen.sv
module tb_period_pulse_gen;

  logic        clk = 1'b0;
  logic        arst;
  logic        ena, per_valid, mode, start, stop;
  logic [15:0] per_data;
  logic        per_ready, pulse, busy, start_err;
  logic [15:0] count;

  logic        ena4, per_valid4, mode4, start4, stop4;
  logic [3:0]  per_data4;
  logic        per_ready4, pulse4, busy4, start_err4;
  logic [3:0]  count4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  period_pulse_gen #(.WIDTH(16)) u_dut (
    .clk(clk), .arst(arst), .ena(ena), .per_data(per_data),
    .per_valid(per_valid), .per_ready(per_ready), .mode(mode),
    .start(start), .stop(stop), .pulse(pulse), .busy(busy),
    .count(count), .start_err(start_err)
  );

  period_pulse_gen #(.WIDTH(4)) u_dut4 (
    .clk(clk), .arst(arst), .ena(ena4), .per_data(per_data4),
    .per_valid(per_valid4), .per_ready(per_ready4), .mode(mode4),
    .start(start4), .stop(stop4), .pulse(pulse4), .busy(busy4),
    .count(count4), .start_err(start_err4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load16(input logic [15:0] p);
    per_data  = p;
    per_valid = 1'b1;
    tick();
    per_valid = 1'b0;
  endtask

  task automatic start16(input logic m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // P=4 continuous run from a fresh start: counts 4,3,2,1,4..., pulse every 4
  task automatic run_p4(input string tag, input int ncyc);
    load16(16'd4);
    start16(1'b0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_cnt0"}, 32'(count), 32'd4);
    chk({tag, "_rdy0"}, 32'(per_ready), 32'd1);
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      chk({tag, "_cnt"}, 32'(count), (k % 4 == 0) ? 32'd4 : 32'(4 - k % 4));
      chk({tag, "_pulse"}, 32'(pulse), (k % 4 == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int e, npulse, last_i, spacing;
    arst = 1'b1;
    ena = 1'b0; per_valid = 1'b0; mode = 1'b0; start = 1'b0; stop = 1'b0;
    per_data = '0;
    ena4 = 1'b0; per_valid4 = 1'b0; mode4 = 1'b0; start4 = 1'b0; stop4 = 1'b0;
    per_data4 = '0;
    #12;
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_err", 32'(start_err), 32'd0);
    chk("rst_rdy", 32'(per_ready), 32'd1);
    arst = 1'b0;
    tick();

    // 1: continuous P=4
    ena = 1'b1;
    load16(16'd4);
    chk("t1_rdy_full", 32'(per_ready), 32'd0);
    per_data = 16'd4; per_valid = 1'b0;
    start16(1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cnt0", 32'(count), 32'd4);
    chk("t1_rdy", 32'(per_ready), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t1_cnt", 32'(count), (k % 4 == 0) ? 32'd4 : 32'(4 - k % 4));
      chk("t1_pulse", 32'(pulse), (k % 4 == 0) ? 32'd1 : 32'd0);
    end

    // 2: write period 3 mid-period; takes effect at next terminal count
    load16(16'd3);
    chk("t2_cnt_a", 32'(count), 32'd3);
    chk("t2_rdy_a", 32'(per_ready), 32'd0);
    tick();
    chk("t2_cnt_b", 32'(count), 32'd2);
    chk("t2_rdy_b", 32'(per_ready), 32'd0);
    tick();
    chk("t2_cnt_c", 32'(count), 32'd1);
    chk("t2_pulse_c", 32'(pulse), 32'd0);
    tick();
    chk("t2_pulse_d", 32'(pulse), 32'd1);
    chk("t2_cnt_d", 32'(count), 32'd3);
    chk("t2_rdy_d", 32'(per_ready), 32'd1);
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("t2_cnt", 32'(count), (j % 3 == 0) ? 32'd3 : 32'(3 - j % 3));
      chk("t2_pulse", 32'(pulse), (j % 3 == 0) ? 32'd1 : 32'd0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_stop_busy", 32'(busy), 32'd0);
    chk("t2_stop_cnt", 32'(count), 32'd0);

    // 3: one-shot P=2, then start with empty shadow
    load16(16'd2);
    start16(1'b1);
    chk("t3_busy0", 32'(busy), 32'd1);
    chk("t3_cnt0", 32'(count), 32'd2);
    tick();
    chk("t3_cnt1", 32'(count), 32'd1);
    chk("t3_pulse1", 32'(pulse), 32'd0);
    tick();
    chk("t3_pulse2", 32'(pulse), 32'd1);
    chk("t3_busy2", 32'(busy), 32'd0);
    chk("t3_cnt2", 32'(count), 32'd0);
    tick();
    chk("t3_pulse3", 32'(pulse), 32'd0);
    start16(1'b0);
    chk("t3_err", 32'(start_err), 32'd1);
    chk("t3_err_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_err_clr", 32'(start_err), 32'd0);

    // 4: continuous P=8, preload 5, stop at count 5
    load16(16'd8);
    start16(1'b0);
    chk("t4_cnt0", 32'(count), 32'd8);
    load16(16'd5);
    chk("t4_cnt1", 32'(count), 32'd7);
    tick();
    tick();
    chk("t4_cnt3", 32'(count), 32'd5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_cnt", 32'(count), 32'd0);
    chk("t4_pulse", 32'(pulse), 32'd0);
    chk("t4_rdy", 32'(per_ready), 32'd0);
    start16(1'b0);
    chk("t4_kept", 32'(count), 32'd5);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // 5: WIDTH=4, P=0 -> 16-cycle period; then 50% enable
    per_data4 = 4'd0; per_valid4 = 1'b1;
    tick();
    per_valid4 = 1'b0;
    ena4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("t5_busy", 32'(busy4), 32'd1);
    chk("t5_cnt0", 32'(count4), 32'd0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("t5_cnt", 32'(count4), 32'((-k) & 15));
      chk("t5_pulse", 32'(pulse4), (k % 16 == 0) ? 32'd1 : 32'd0);
    end
    e = 32; npulse = 0; last_i = -1; spacing = 0;
    for (int i = 0; i < 64; i++) begin
      ena4 = (i % 2 == 0);
      tick();
      if (ena4) e++;
      chk("t5h_cnt", 32'(count4), 32'((-e) & 15));
      if (pulse4) begin
        npulse++;
        if (last_i >= 0) spacing = i - last_i;
        last_i = i;
      end
    end
    chk("t5h_npulse", 32'(npulse), 32'd2);
    chk("t5h_spacing", 32'(spacing), 32'd32);
    ena4 = 1'b0; stop4 = 1'b1;
    tick();
    stop4 = 1'b0;

    // 6: async reset mid-RUN, then a clean restart
    load16(16'd4);
    start16(1'b0);
    tick();
    chk("t6_pre_cnt", 32'(count), 32'd3);
    #2 arst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cnt", 32'(count), 32'd0);
    chk("t6_pulse", 32'(pulse), 32'd0);
    chk("t6_rdy", 32'(per_ready), 32'd1);
    chk("t6_err", 32'(start_err), 32'd0);
    @(posedge clk);
    #3 arst = 1'b0;
    tick();
    run_p4("t6r", 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
